// File: rtl/mult_pkg.sv
// Shared widths and FSM encoding for the iterative shift-add multiplier.
package mult_pkg;
  localparam int M_W   = 29;
  localparam int N_W   = 22;
  localparam int P_W   = 51;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
endpackage

// File: rtl/customAdder51_22.sv
// Zero-extending adder: A_W-bit a plus B_W-bit b, full (A_W+1)-bit sum.
module customAdder51_22 #(
  parameter int A_W = 51,
  parameter int B_W = 29
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W:0]   sum
);
  assign sum = {1'b0, a} + {{(A_W + 1 - B_W){1'b0}}, b};
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned M_W x N_W multiplier, one multiplier bit per clock MSB first,
// with valid/ready on the operand and product sides.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int M_W   = mult_pkg::M_W,
  parameter int N_W   = mult_pkg::N_W,
  parameter int P_W   = mult_pkg::P_W,
  parameter int CNT_W = mult_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M_W-1:0] in_mcand,
  input  logic [N_W-1:0] in_mplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_prod,
  output logic           busy
);

  if (P_W != M_W + N_W) begin : g_bad_pw
    $error("P_W must equal M_W + N_W");
  end
  if (CNT_W < $clog2(N_W)) begin : g_bad_cnt
    $error("CNT_W too narrow for N_W steps");
  end

  mult_state_t    state;
  logic [M_W-1:0] mcand;
  logic [N_W-1:0] mplier;
  logic [P_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0] add_a;
  logic [M_W-1:0] add_b;
  logic [P_W:0]   sum;
  logic           accept;

  assign add_a = {acc[P_W-2:0], 1'b0};
  assign add_b = mplier[N_W-1] ? mcand : '0;

  customAdder51_22 #(.A_W(P_W), .B_W(M_W)) u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (sum)
  );

  // DONE can hand off straight to a new op, so in_ready looks through out_ready.
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign out_prod = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= in_mcand;
            mplier <= in_mplier;
            acc    <= '0;
            cnt    <= CNT_W'(N_W - 1);
            state  <= RUN;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          acc    <= sum[P_W-1:0];
          mplier <= mplier << 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              mcand  <= in_mcand;
              mplier <= in_mplier;
              acc    <= '0;
              cnt    <= CNT_W'(N_W - 1);
              state  <= RUN;
              busy   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // acc stays below 2^P_W, so the step sum can never carry out.
  a_no_carry: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> !sum[P_W]);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and random checks of the iterative multiplier against hand values
// and a behavioural product.
module tb_seq_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [28:0] in_mcand = '0;
  logic [21:0] in_mplier = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [50:0] out_prod;
  logic        busy;

  int total = 0;
  int bad   = 0;

  seq_shift_add_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mcand  (in_mcand),
    .in_mplier (in_mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Present one operand pair for a single edge; returns on the following negedge.
  task automatic launch(input logic [28:0] mc, input logic [21:0] mp);
    in_valid  = 1'b1;
    in_mcand  = mc;
    in_mplier = mp;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++; $display("FAIL reset_flags got v/b/r=%b want=001", {out_valid, busy, in_ready});
    end
    total++;
    if (out_prod !== 51'd0) begin
      bad++; $display("FAIL reset_prod got=%0h want=0", out_prod);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++; $display("FAIL idle_flags got v/b/r=%b want=001", {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    launch(29'd3, 22'd5);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_run got busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready);
    end
    wait_done(lat);
    total++;
    if (lat !== 22) begin
      bad++; $display("FAIL basic_latency got=%0d want=22", lat);
    end
    total++;
    if (out_prod !== 51'd15) begin
      bad++; $display("FAIL basic_prod got=%0d want=15", out_prod);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_ready_done got=%b want=1", in_ready);
    end
    @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL basic_back_idle got v/r=%b want=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_max();
    int lat;
    launch(29'h1FFF_FFFF, 22'h3F_FFFF);
    wait_done(lat);
    total++;
    if (lat !== 22) begin
      bad++; $display("FAIL max_latency got=%0d want=22", lat);
    end
    total++;
    if (out_prod !== 51'h7_FFFF_DFC0_0001) begin
      bad++; $display("FAIL max_prod got=%0h want=7ffffdfc00001", out_prod);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat;
    logic [28:0] mcs [2];
    logic [21:0] mps [2];
    mcs[0] = 29'h123_4567; mps[0] = 22'd0;
    mcs[1] = 29'd0;        mps[1] = 22'h3F_FFFF;
    for (int i = 0; i < 2; i++) begin
      launch(mcs[i], mps[i]);
      wait_done(lat);
      total++;
      if (lat !== 22) begin
        bad++; $display("FAIL zero_latency_%0d got=%0d want=22", i, lat);
      end
      total++;
      if (out_prod !== 51'd0) begin
        bad++; $display("FAIL zero_prod_%0d got=%0h want=0", i, out_prod);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int lat;
    out_ready = 1'b0;
    launch(29'd1234, 22'd567);
    wait_done(lat);
    total++;
    if (lat !== 22) begin
      bad++; $display("FAIL stall_latency got=%0d want=22", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, out_prod} !== {1'b1, 1'b0, 51'd699678}) begin
        bad++; $display("FAIL stall_hold_%0d got v=%b r=%b prod=%0d want v=1 r=0 prod=699678",
                        i, out_valid, in_ready, out_prod);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mcand  = 29'd11;
    in_mplier = 22'd13;
    #1;
    total++;
    if ({in_ready, out_valid, out_prod} !== {1'b1, 1'b1, 51'd699678}) begin
      bad++; $display("FAIL stall_handoff got r=%b v=%b prod=%0d want r=1 v=1 prod=699678",
                      in_ready, out_valid, out_prod);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({out_valid, busy} !== 2'b01) begin
      bad++; $display("FAIL stall_reaccept got v/b=%b want=01", {out_valid, busy});
    end
    wait_done(lat);
    total++;
    if (lat !== 22 || out_prod !== 51'd143) begin
      bad++; $display("FAIL stall_next got lat=%0d prod=%0d want lat=22 prod=143", lat, out_prod);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_in_valid();
    int lat;
    launch(29'd6, 22'd7);
    in_valid  = 1'b1;
    in_mcand  = 29'd99;
    in_mplier = 22'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready, busy} !== 2'b01) begin
        bad++; $display("FAIL hold_run_%0d got r/b=%b want=01", i, {in_ready, busy});
      end
    end
    in_valid = 1'b0;
    wait_done(lat);
    total++;
    if (out_prod !== 51'd42) begin
      bad++; $display("FAIL hold_prod got=%0d want=42", out_prod);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic spurious;
    launch(29'd100, 22'd200);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++; $display("FAIL rstmid_flags got v/b/r=%b want=001", {out_valid, busy, in_ready});
    end
    spurious = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious = 1'b1;
    end
    total++;
    if (spurious !== 1'b0) begin
      bad++; $display("FAIL rstmid_spurious got out_valid=1 want=0");
    end
    launch(29'd7, 22'd9);
    wait_done(lat);
    total++;
    if (lat !== 22 || out_prod !== 51'd63) begin
      bad++; $display("FAIL rstmid_fresh got lat=%0d prod=%0d want lat=22 prod=63", lat, out_prod);
    end
    @(negedge clk);
    out_ready = 1'b0;
    launch(29'd5, 22'd5);
    wait_done(lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01 || out_prod !== 51'd0) begin
      bad++; $display("FAIL rstdone got v/r=%b prod=%0d want v/r=01 prod=0", {out_valid, in_ready}, out_prod);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [50:0] q[$];
    logic [50:0] e;
    logic [28:0] mc;
    logic [21:0] mp;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    mc = 29'($urandom());
    mp = 22'($urandom());
    while (got < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = (sent < 1000);
      in_mcand  = mc;
      in_mplier = mp;
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got prod=%0h with nothing outstanding", out_prod);
        end else begin
          e = q.pop_front();
          if (out_prod !== e) begin
            bad++; $display("FAIL b2b_prod_%0d got=%0h want=%0h", got, out_prod, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back({22'd0, mc} * {29'd0, mp});
        sent++;
        mc = ($urandom_range(0, 15) == 0) ? 29'd0 : 29'($urandom());
        mp = ($urandom_range(0, 15) == 0) ? 22'd0 : 22'($urandom());
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got !== 1000 || q.size() !== 0) begin
      bad++; $display("FAIL b2b_count got=%0d left=%0d want got=1000 left=0", got, q.size());
    end
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain got out_valid=%b want=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_stall();
    test_hold_in_valid();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
